insn_mem_resp: RTL and testbench
================================

Name: insn_mem_resp

Overview:
Instruction-memory responder on the far side of the fetch interface. It accepts byte-addressed fetch requests from the fetch stage and returns a 32-bit instruction one cycle later from an internal word array. The array is loaded through a separate load port before the core runs. Misaligned and out-of-range fetches are reported as faults, and the returned slot is filled with a NOP.

Parameters:
ADDR_WIDTH, 32, fetch/PC byte-address width
INSN_WIDTH, 32, instruction word width
DEPTH_WORDS, 1024, array depth in words (power of two)
LD_AW, 10, load word-index width (log2 DEPTH_WORDS)
NOP_INSN, 32'h0000_0013, instruction returned on fault or squash fill

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
cpu_en  in  1  core run enable
fetch_req  in  1  fetch request valid
fetch_addr  in  ADDR_WIDTH  fetch byte address
fetch_ready  out  1  request accepted this cycle when fetch_req=1
flush  in  1  branch/redirect flush; kills in-flight response, clears fault
ld_en  in  1  array write strobe (program load)
ld_addr  in  LD_AW  word index for load
ld_data  in  INSN_WIDTH  word to load
insn  out  INSN_WIDTH  returned instruction
insn_pc  out  ADDR_WIDTH  byte address of returned instruction
insn_valid  out  1  response valid (one-cycle pulse per accepted request)
fetch_err  out  1  response is a fault (qualifies insn_valid)
err_addr  out  ADDR_WIDTH  address of most recent fault, sticky
fetch_cnt  out  16  count of good responses, saturating

Behaviour:
- Reset values: state=LOAD, insn=0, insn_pc=0, insn_valid=0, fetch_err=0, err_addr=0, fetch_cnt=0. Reset does not clear the array.
- States:
  - LOAD: ld_en writes ld_data to array[ld_addr] on the clock edge. fetch_ready=0. Go to RUN when cpu_en=1 and ld_en=0.
  - RUN: fetch_ready = !flush. ld_en is ignored.
  - ERR: fetch_ready=0. Go to RUN on flush.
  - Any state with cpu_en=0 goes to LOAD next cycle, and any pending response is squashed.
- Accept: fetch_req & fetch_ready at edge N. At edge N+1 the response registers are written: insn_valid=1, insn_pc=fetch_addr. Latency is exactly 1 cycle. Throughput is 1 request/cycle, back-to-back.
- Good fetch: fetch_addr[1:0]==0 and fetch_addr[ADDR_WIDTH-1:2] < DEPTH_WORDS. Then insn=array[fetch_addr>>2], fetch_err=0, and fetch_cnt increments (holds at 16'hFFFF).
- Fault (misaligned, or out of range): insn=NOP_INSN, fetch_err=1, err_addr=fetch_addr, state goes to ERR. If both conditions hold, a single fault is reported.
- Non-accept cycles: insn_valid=0 and fetch_err=0. insn and insn_pc hold their last values.
- flush at edge N: no request is accepted at N. The response for a request accepted at N-1 is still delivered at N (it is already registered). In ERR, flush returns to RUN; err_addr stays sticky.
- Simultaneous events:
  - ld_en with fetch_req in LOAD: load wins, fetch is not accepted.
  - cpu_en falling with an accepted request: the response is squashed (insn_valid=0).
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), state=LOAD, array contents preserved.
- Array: synchronous write, registered read, no bypass. A load to a word and a fetch of that word in the same cycle cannot occur (modes are exclusive).

Test Plan:
1. Reset, load words 0..3 = 11,22,33,44 (hex); cpu_en=1; fetch 0x0,0x4,0x8,0xC back-to-back -> insn 11,22,33,44 on consecutive cycles, each 1 cycle after its request; insn_pc matches; fetch_cnt=4.
2. In RUN, fetch 0x6 -> next cycle insn_valid=1, fetch_err=1, insn=0x00000013, err_addr=0x6; fetch_ready=0 until flush; a flush then gives fetch_ready=1 the next cycle.
3. Fetch 0x1000 with DEPTH_WORDS=1024 -> fault, err_addr=0x1000, state ERR; fetch 0xFFC -> good response with array[1023].
4. Request at N, flush at N+1 with fetch_req high -> response for N delivered at N+1; request at N+1 not accepted; insn_valid=0 at N+2.
5. Accept a request, drop cpu_en the same cycle -> insn_valid stays 0; state LOAD; ld_en writes word 5; re-enable, fetch 0x14 -> new data.
6. Preload fetch_cnt near 0xFFFF via 65536 good fetches -> fetch_cnt holds 0xFFFF. Assert reset mid-burst -> all outputs 0, state LOAD, array data intact on refetch.

Source files
------------

// File: rtl/insn_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : insn_mem_resp                                          |
// | Description : Instruction-memory responder behind the fetch port.    |
// |               Program is loaded through a word-indexed load port     |
// |               while the core is held; in run mode byte-addressed     |
// |               fetches are answered one cycle after acceptance, with  |
// |               misaligned/out-of-range fetches reported as faults and |
// |               filled with a NOP.                                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module insn_mem_resp #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSN_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    LD_AW       = 10,
  parameter logic [INSN_WIDTH-1:0] NOP_INSN    = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_en,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [LD_AW-1:0]      ld_addr,
  input  logic [INSN_WIDTH-1:0] ld_data,
  output logic [INSN_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  output logic                  insn_valid,
  output logic                  fetch_err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [15:0]           fetch_cnt
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_fetch_ready;

  logic [INSN_WIDTH-1:0]   r_mem [DEPTH_WORDS];
  logic [INSN_WIDTH-1:0]   r_rd_data;

  // Request stage: captured on the accept edge.
  logic                    r_p_valid;
  logic                    r_p_good;
  logic [ADDR_WIDTH-1:0]   r_p_addr;

  // Response stage: visible on the ports.
  logic [INSN_WIDTH-1:0]   r_insn;
  logic [ADDR_WIDTH-1:0]   r_insn_pc;
  logic                    r_insn_valid;
  logic                    r_fetch_err;
  logic [ADDR_WIDTH-1:0]   r_err_addr;
  logic [15:0]             r_fetch_cnt;

  logic                    w_aligned;
  logic                    w_in_range;
  logic                    w_good;
  logic                    w_accept;
  logic                    w_take;
  logic                    w_resp;
  logic [LD_AW-1:0]        w_idx;

  assign w_aligned  = (fetch_addr[1:0] == 2'b00);
  assign w_in_range = (fetch_addr[ADDR_WIDTH-1:LD_AW+2] == '0);
  assign w_good     = w_aligned & w_in_range;
  assign w_idx      = fetch_addr[LD_AW+1:2];
  assign w_accept   = fetch_req & w_fetch_ready;
  // A request accepted while the core is being disabled is squashed at once.
  assign w_take     = w_accept & cpu_en;
  // A registered request only becomes a response while the core stays enabled.
  assign w_resp     = r_p_valid & cpu_en;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake: faults park in ERR from the accept edge so no
  // further requests slip in behind a faulting one.
  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_ready = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (cpu_en && !ld_en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_fetch_ready = !flush;
        if (w_accept && !w_good) w_state_nxt = ST_ERR;
      end
      ST_ERR: begin
        if (flush) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
    if (!cpu_en) w_state_nxt = ST_LOAD;
  end

  // Word array: program load in LOAD only, registered read on accept.
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD && ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
    if (w_take) begin
      r_rd_data <= r_mem[w_idx];
    end
  end

  // Request stage: remember what was accepted and whether it is legal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p_valid <= 1'b0;
      r_p_good  <= 1'b0;
      r_p_addr  <= '0;
    end else begin
      r_p_valid <= w_take;
      if (w_take) begin
        r_p_good <= w_good;
        r_p_addr <= fetch_addr;
      end
    end
  end

  // Response stage: one-cycle pulse, NOP fill and sticky address on fault,
  // saturating count of good responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_insn       <= '0;
      r_insn_pc    <= '0;
      r_insn_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_err_addr   <= '0;
      r_fetch_cnt  <= '0;
    end else begin
      r_insn_valid <= w_resp;
      r_fetch_err  <= w_resp & ~r_p_good;
      if (w_resp) begin
        r_insn_pc <= r_p_addr;
        if (r_p_good) begin
          r_insn <= r_rd_data;
          if (r_fetch_cnt != 16'hFFFF) r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end else begin
          r_insn     <= NOP_INSN;
          r_err_addr <= r_p_addr;
        end
      end
    end
  end

  assign fetch_ready = w_fetch_ready;
  assign insn        = r_insn;
  assign insn_pc     = r_insn_pc;
  assign insn_valid  = r_insn_valid;
  assign fetch_err   = r_fetch_err;
  assign err_addr    = r_err_addr;
  assign fetch_cnt   = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_insn_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_insn_mem_resp                                       |
// | Description : Directed bench for insn_mem_resp. Stimulus pushes the  |
// |               expected response into a scoreboard queue; a monitor   |
// |               pops and compares whenever insn_valid is seen.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_insn_mem_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        flush;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic        fetch_err;
  logic [31:0] err_addr;
  logic [15:0] fetch_cnt;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  insn_mem_resp dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .flush      (flush),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .insn       (insn),
    .insn_pc    (insn_pc),
    .insn_valid (insn_valid),
    .fetch_err  (fetch_err),
    .err_addr   (err_addr),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index used to check exact response latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (insn_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL resp: unexpected response insn=%h pc=%h err=%b, required no response",
                 insn, insn_pc, fetch_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (insn === e.insn && insn_pc === e.pc && fetch_err === e.err && cyc == e.due)
          n_pass++;
        else
          $display("FAIL resp: got insn=%h pc=%h err=%b cyc=%0d, required insn=%h pc=%h err=%b cyc=%0d",
                   insn, insn_pc, fetch_err, cyc, e.insn, e.pc, e.err, e.due);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive one fetch that must be accepted and queue its expected response.
  task automatic issue(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    exp_t e;
    fetch_req  = 1'b1;
    fetch_addr = a;
    #1;
    chk("fetch_ready_on_issue", {31'd0, fetch_ready}, 32'd1);
    e.insn = ei; e.pc = a; e.err = ee; e.due = cyc + 2;
    sb.push_back(e);
    step();
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
  endtask

  initial begin
    reset = 1'b1; cpu_en = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    step(); step();

    // Reset state.
    chk("rst_insn",       insn,                   32'd0);
    chk("rst_insn_pc",    insn_pc,                32'd0);
    chk("rst_valid_err",  {30'd0, insn_valid, fetch_err}, 32'd0);
    chk("rst_err_addr",   err_addr,               32'd0);
    chk("rst_fetch_cnt",  {16'd0, fetch_cnt},     32'd0);
    chk("rst_ready",      {31'd0, fetch_ready},   32'd0);
    reset = 1'b0;
    step();

    // Load while a fetch is requested and the core is enabled: load wins.
    cpu_en = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
    ld_en = 1'b1; ld_addr = 10'd0; ld_data = 32'h11;
    #1;
    chk("load_blocks_fetch", {31'd0, fetch_ready}, 32'd0);
    step();
    load(10'd1, 32'h22);
    load(10'd2, 32'h33);
    load(10'd3, 32'h44);
    load(10'd1023, 32'hDEAD_BEEF);
    load(10'd5, 32'h0000_0055);
    ld_en = 1'b0; fetch_req = 1'b0;
    step();

    // Back-to-back good fetches.
    issue(32'h0, 32'h11, 1'b0);
    issue(32'h4, 32'h22, 1'b0);
    issue(32'h8, 32'h33, 1'b0);
    issue(32'hC, 32'h44, 1'b0);
    fetch_req = 1'b0;
    step(); step();
    chk("cnt_after_burst", {16'd0, fetch_cnt}, 32'd4);

    // Misaligned fetch faults and parks in ERR until a flush.
    issue(32'h6, NOP, 1'b1);
    fetch_req = 1'b0;
    step();
    chk("err_addr_misalign", err_addr, 32'h6);
    chk("err_ready_low",     {31'd0, fetch_ready}, 32'd0);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("ready_after_flush", {31'd0, fetch_ready}, 32'd1);
    chk("err_addr_sticky",   err_addr, 32'h6);

    // Out-of-range fetch faults; highest word is still reachable.
    issue(32'h1000, NOP, 1'b1);
    fetch_req = 1'b0;
    step();
    chk("err_addr_range", err_addr, 32'h1000);
    chk("range_ready_low", {31'd0, fetch_ready}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    issue(32'hFFC, 32'hDEAD_BEEF, 1'b0);
    fetch_req = 1'b0;
    step(); step();

    // Flush right behind an accepted request: that response still arrives,
    // the concurrent request is refused.
    issue(32'h8, 32'h33, 1'b0);
    flush = 1'b1; fetch_req = 1'b1; fetch_addr = 32'hC;
    #1;
    chk("flush_blocks_ready", {31'd0, fetch_ready}, 32'd0);
    step();
    flush = 1'b0; fetch_req = 1'b0;
    step();
    chk("flush_no_resp", {31'd0, insn_valid}, 32'd0);

    // Accept while dropping cpu_en: response squashed, back to LOAD.
    cpu_en = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
    #1;
    chk("ready_at_cpu_drop", {31'd0, fetch_ready}, 32'd1);
    step();
    fetch_req = 1'b0;
    #1;
    chk("load_ready_low", {31'd0, fetch_ready}, 32'd0);
    step();
    chk("squash_no_resp", {31'd0, insn_valid}, 32'd0);
    load(10'd5, 32'hA5A5_0005);
    ld_en = 1'b0; cpu_en = 1'b1;
    step();
    issue(32'h14, 32'hA5A5_0005, 1'b0);
    fetch_req = 1'b0;
    step(); step();
    chk("cnt_good_only", {16'd0, fetch_cnt}, 32'd7);

    // Long burst to saturate the counter.
    for (int i = 0; i < 65536; i++) begin
      exp_t e;
      fetch_req  = 1'b1;
      fetch_addr = 32'(i % 4) << 2;
      e.insn = 32'h11 * 32'((i % 4) + 1);
      e.pc = fetch_addr; e.err = 1'b0; e.due = cyc + 2;
      sb.push_back(e);
      step();
    end
    chk("cnt_saturated", {16'd0, fetch_cnt}, 32'h0000_FFFF);

    // Asynchronous reset in the middle of the burst.
    fetch_req = 1'b1; fetch_addr = 32'h4;
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_insn",      insn,                   32'd0);
    chk("mid_rst_insn_pc",   insn_pc,                32'd0);
    chk("mid_rst_valid_err", {30'd0, insn_valid, fetch_err}, 32'd0);
    chk("mid_rst_err_addr",  err_addr,               32'd0);
    chk("mid_rst_fetch_cnt", {16'd0, fetch_cnt},     32'd0);
    chk("mid_rst_ready",     {31'd0, fetch_ready},   32'd0);
    step();
    sb.delete();
    fetch_req = 1'b0;
    reset = 1'b0;
    step();

    // Array contents survive reset.
    issue(32'h0,   32'h11,        1'b0);
    issue(32'h4,   32'h22,        1'b0);
    issue(32'hFFC, 32'hDEAD_BEEF, 1'b0);
    issue(32'h14,  32'hA5A5_0005, 1'b0);
    fetch_req = 1'b0;
    step(); step();
    chk("cnt_after_reset", {16'd0, fetch_cnt}, 32'd4);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
